// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 1-bit-per-cycle shift engine between two requesters.
// Optional feature: define ROTATE_EN to honour reqK_rot (rotate instead of logical shift).
module shift_arbiter #(
  parameter int W  = 8,
  parameter int NW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic          req0_d,
  input  logic [NW-1:0] req0_n,
  input  logic          req0_rot,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic          req1_d,
  input  logic [NW-1:0] req1_n,
  input  logic          req1_rot,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_x,
  output logic          res_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sh;
  logic [NW-1:0] cnt;
  logic          dir;
  logic          id;
  logic          last;
  logic          g0, g1, acc;
  logic [W-1:0]  sel_a;
  logic          sel_d;
  logic [NW-1:0] sel_n;
  logic [W-1:0]  step;
  logic          fill_l, fill_r;

`ifdef ROTATE_EN
  logic rot;
  logic sel_rot;
  assign sel_rot = g1 ? req1_rot : req0_rot;
  assign fill_l  = rot & sh[W-1];
  assign fill_r  = rot & sh[0];
`else
  logic unused_rot;
  assign unused_rot = req0_rot ^ req1_rot;
  assign fill_l     = 1'b0;
  assign fill_r     = 1'b0;
`endif

  // last==1 means req1 won most recently, so req0 gets priority on a tie
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && (!req1_valid || last))
        g0 = 1'b1;
      else if (req1_valid)
        g1 = 1'b1;
    end
  end

  assign acc   = g0 | g1;
  assign sel_a = g1 ? req1_a : req0_a;
  assign sel_d = g1 ? req1_d : req0_d;
  assign sel_n = g1 ? req1_n : req0_n;

  always_comb begin
    if (dir)
      step = {sh[W-2:0], fill_l};
    else
      step = {fill_r, sh[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = (sel_n == '0) ? DONE : RUN;
      RUN:  if (cnt == NW'(1)) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = g0;
    req1_ready = g1;
    res_valid  = (state == DONE);
    res_x      = sh;
    res_id     = id;
  end

  // Operand capture on accept, then one shift per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
      id   <= 1'b0;
      last <= 1'b1;
`ifdef ROTATE_EN
      rot  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            sh   <= sel_a;
            cnt  <= sel_n;
            dir  <= sel_d;
            id   <= g1;
            last <= g1;
`ifdef ROTATE_EN
            rot  <= sel_rot;
`endif
          end
        end
        RUN: begin
          sh  <= step;
          cnt <= cnt - NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
